// File: rtl/cmp_arbiter_pkg.sv
// Shared constants and FSM encoding for the round-robin comparator arbiter.
package cmp_arbiter_pkg;

  localparam int CMP_W   = 8;
  localparam int COUNT_W = 16;

  typedef enum logic [1:0] {
    IDLE    = 2'd0,
    COMPARE = 2'd1,
    RESP    = 2'd2
  } state_t;

endpackage

// File: rtl/cmp_core.sv
// Combinational 8-bit magnitude compare using a + ~b + cin; carry-out set means a >= b.
module cmp_core
  import cmp_arbiter_pkg::*;
(
  input  logic [CMP_W-1:0] a,
  input  logic [CMP_W-1:0] b,
  input  logic             cin,
  output logic             leq,
  output logic             zero
);

  logic [CMP_W:0] sum;

  assign sum  = {1'b0, a} + {1'b0, ~b} + {{CMP_W{1'b0}}, cin};
  assign zero = (a == b);
  assign leq  = ~sum[CMP_W] | zero;

endmodule

// File: rtl/cmp_arbiter.sv
// Round-robin arbiter sharing one comparator core among N_REQ requesters.
// Optional completed-compare counter output enabled by CMP_ARBITER_COUNT_EN.
module cmp_arbiter
  import cmp_arbiter_pkg::*;
#(
  parameter int N_REQ  = 4,
  parameter int DATA_W = 8
) (
  input  logic                    clk,
  input  logic                    rst,
  input  logic [N_REQ-1:0]        req,
  input  logic [N_REQ*DATA_W-1:0] a_flat,
  input  logic [N_REQ*DATA_W-1:0] b_flat,
  output logic [N_REQ-1:0]        grant,
  output logic [N_REQ-1:0]        done,
  output logic                    leq,
  output logic                    zero,
  output logic                    busy
`ifdef CMP_ARBITER_COUNT_EN
  ,
  output logic [COUNT_W-1:0]      cmp_count
`endif
);

  localparam int IDX_W = (N_REQ > 1) ? $clog2(N_REQ) : 1;
  localparam logic [IDX_W:0] N_IDX = (IDX_W+1)'(N_REQ);

  state_t              state_reg;
  logic [N_REQ-1:0]    grant_reg;
  logic [N_REQ-1:0]    done_reg;
  logic                leq_reg;
  logic                zero_reg;
  logic                busy_reg;
  logic [IDX_W-1:0]    rr_ptr_reg;
  logic [IDX_W-1:0]    gidx_reg;
  logic [DATA_W-1:0]   op_a_reg;
  logic [DATA_W-1:0]   op_b_reg;

  logic [DATA_W-1:0]   a_lane [N_REQ];
  logic [DATA_W-1:0]   b_lane [N_REQ];

  genvar gi;
  generate
    for (gi = 0; gi < N_REQ; gi++) begin : g_lane
      assign a_lane[gi] = a_flat[gi*DATA_W +: DATA_W];
      assign b_lane[gi] = b_flat[gi*DATA_W +: DATA_W];
    end
  endgenerate

  // Rotate requests so bit 0 is the current top-priority requester.
  logic [2*N_REQ-1:0] req_rot;
  logic               pick_valid;
  logic [IDX_W-1:0]   pick_idx;
  logic [IDX_W:0]     pick_sum;
  logic [N_REQ-1:0]   pick_onehot;
  logic [IDX_W:0]     rr_sum;
  logic [IDX_W-1:0]   rr_next;

  assign req_rot = {req, req} >> rr_ptr_reg;

  always_comb begin
    pick_valid = 1'b0;
    pick_idx   = '0;
    pick_sum   = '0;
    for (int k = N_REQ - 1; k >= 0; k--) begin
      if (req_rot[k]) begin
        pick_valid = 1'b1;
        pick_sum   = {1'b0, rr_ptr_reg} + (IDX_W+1)'(k);
        if (pick_sum >= N_IDX) begin
          pick_sum = pick_sum - N_IDX;
        end
        pick_idx = pick_sum[IDX_W-1:0];
      end
    end
  end

  assign pick_onehot = N_REQ'(1) << pick_idx;

  always_comb begin
    rr_sum = {1'b0, gidx_reg} + (IDX_W+1)'(1);
    if (rr_sum >= N_IDX) begin
      rr_sum = '0;
    end
    rr_next = rr_sum[IDX_W-1:0];
  end

  logic core_leq;
  logic core_zero;

  cmp_core u_core (
    .a    (op_a_reg),
    .b    (op_b_reg),
    .cin  (1'b1),
    .leq  (core_leq),
    .zero (core_zero)
  );

`ifdef CMP_ARBITER_COUNT_EN
  logic [COUNT_W-1:0] count_reg;
`endif

  always_ff @(posedge clk) begin
    if (rst) begin
      state_reg  <= IDLE;
      grant_reg  <= '0;
      done_reg   <= '0;
      leq_reg    <= 1'b0;
      zero_reg   <= 1'b0;
      busy_reg   <= 1'b0;
      rr_ptr_reg <= '0;
      gidx_reg   <= '0;
      op_a_reg   <= '0;
      op_b_reg   <= '0;
`ifdef CMP_ARBITER_COUNT_EN
      count_reg  <= '0;
`endif
    end else begin
      case (state_reg)
        IDLE: begin
          if (pick_valid) begin
            gidx_reg  <= pick_idx;
            op_a_reg  <= a_lane[pick_idx];
            op_b_reg  <= b_lane[pick_idx];
            grant_reg <= pick_onehot;
            busy_reg  <= 1'b1;
            state_reg <= COMPARE;
          end
        end
        COMPARE: begin
          leq_reg   <= core_leq;
          zero_reg  <= core_zero;
          done_reg  <= grant_reg;
          state_reg <= RESP;
`ifdef CMP_ARBITER_COUNT_EN
          if (count_reg != '1) begin
            count_reg <= count_reg + 1'b1;
          end
`endif
        end
        RESP: begin
          done_reg   <= '0;
          grant_reg  <= '0;
          rr_ptr_reg <= rr_next;
          busy_reg   <= 1'b0;
          state_reg  <= IDLE;
        end
        default: begin
          state_reg <= IDLE;
        end
      endcase
    end
  end

  assign grant = grant_reg;
  assign done  = done_reg;
  assign leq   = leq_reg;
  assign zero  = zero_reg;
  assign busy  = busy_reg;
`ifdef CMP_ARBITER_COUNT_EN
  assign cmp_count = count_reg;
`endif

endmodule

// File: tb/tb_cmp_arbiter.sv
// Scoreboard bench for cmp_arbiter: round-robin order model plus leq/zero reference.
module tb_cmp_arbiter;

  localparam int N = 4;

  logic           clk = 1'b0;
  logic           rst;
  logic [N-1:0]   req;
  logic [N*8-1:0] a_flat;
  logic [N*8-1:0] b_flat;
  logic [N-1:0]   grant;
  logic [N-1:0]   done;
  logic           leq;
  logic           zero;
  logic           busy;
`ifdef CMP_ARBITER_COUNT_EN
  logic [15:0]    cmp_count;
`endif

  cmp_arbiter #(.N_REQ(N), .DATA_W(8)) dut (
    .clk    (clk),
    .rst    (rst),
    .req    (req),
    .a_flat (a_flat),
    .b_flat (b_flat),
    .grant  (grant),
    .done   (done),
    .leq    (leq),
    .zero   (zero),
    .busy   (busy)
`ifdef CMP_ARBITER_COUNT_EN
    ,
    .cmp_count (cmp_count)
`endif
  );

  always #5 clk = ~clk;

  typedef struct {
    int idx;
    bit leq;
    bit zero;
  } exp_t;

  exp_t exp_q[$];
  int   tests     = 0;
  int   fails     = 0;
  int   model_rr  = 0;
  int   exp_count = 0;
  int   lane_a [N];
  int   lane_b [N];

  task automatic chk(input string name, input longint act, input longint expv);
    tests++;
    if (act !== expv) begin
      fails++;
      $display("FAIL %s: got %0d, expected %0d", name, act, expv);
    end
  endtask

  function automatic int next_pick(input logic [N-1:0] m, input int rr);
    for (int k = 0; k < N; k++) begin
      if (m[(rr + k) % N]) return (rr + k) % N;
    end
    return -1;
  endfunction

  function automatic exp_t make_exp(input int idx);
    exp_t e;
    e.idx  = idx;
    e.leq  = (lane_a[idx] <= lane_b[idx]);
    e.zero = (lane_a[idx] == lane_b[idx]);
    return e;
  endfunction

  // Monitor: every done pulse is matched against the oldest expected response.
  always @(negedge clk) begin
    if (!rst && done != '0) begin
      if (exp_q.size() == 0) begin
        chk("unexpected_done", longint'(done), 0);
      end else begin
        exp_t e;
        e = exp_q.pop_front();
        chk("done_onehot", longint'(done), longint'(1) << e.idx);
        chk("leq", longint'(leq), longint'(e.leq));
        chk("zero", longint'(zero), longint'(e.zero));
        $display("[TB] done lane %0d a=%0d b=%0d leq=%0d zero=%0d",
                 e.idx, lane_a[e.idx], lane_b[e.idx], leq, zero);
        exp_count++;
      end
    end
  end

  task automatic drive_lanes();
    for (int i = 0; i < N; i++) begin
      a_flat[i*8 +: 8] = 8'(lane_a[i]);
      b_flat[i*8 +: 8] = 8'(lane_b[i]);
    end
  endtask

  // holds == 0: each requester drops req on its own done.
  // holds > 0: mask held for that many completions, then all dropped.
  task automatic run_batch(input logic [N-1:0] mask, input int holds, input bit scramble);
    logic [N-1:0] rem;
    logic [N-1:0] prev_grant;
    int n_exp;
    int n_done;
    int cyc;
    int idx;
    n_exp = 0;
    rem   = mask;
    if (holds == 0) begin
      while (rem != '0) begin
        idx = next_pick(rem, model_rr);
        exp_q.push_back(make_exp(idx));
        rem[idx] = 1'b0;
        model_rr = (idx + 1) % N;
        n_exp++;
      end
    end else begin
      for (int h = 0; h < holds; h++) begin
        idx = next_pick(mask, model_rr);
        exp_q.push_back(make_exp(idx));
        model_rr = (idx + 1) % N;
        n_exp++;
      end
    end
    drive_lanes();
    req        = mask;
    n_done     = 0;
    cyc        = 0;
    prev_grant = '0;
    while (n_done < n_exp && cyc < 3 * n_exp + 10) begin
      @(posedge clk);
      @(negedge clk);
      cyc++;
      if (scramble && grant != '0 && prev_grant == '0) begin
        for (int i = 0; i < N; i++) begin
          if (grant[i]) a_flat[i*8 +: 8] = 8'($urandom_range(0, 255));
        end
      end
      prev_grant = grant;
      if (done != '0) begin
        n_done++;
        if (holds == 0) req = req & ~done;
        else if (n_done == holds) req = '0;
      end
    end
    chk("batch_completions", n_done, n_exp);
    req = '0;
    @(posedge clk);
    @(negedge clk);
    chk("busy_after_batch", longint'(busy), 0);
  endtask

  task automatic single(input int lane, input int a, input int b);
    lane_a[lane] = a;
    lane_b[lane] = b;
    run_batch(N'(1) << lane, 0, 1'b0);
  endtask

  initial begin
    #2_000_000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  initial begin
    rst    = 1'b1;
    req    = '0;
    a_flat = '0;
    b_flat = '0;
    for (int i = 0; i < N; i++) begin
      lane_a[i] = 0;
      lane_b[i] = 0;
    end
    repeat (3) @(posedge clk);
    @(negedge clk);
    chk("reset_grant", longint'(grant), 0);
    chk("reset_done", longint'(done), 0);
    chk("reset_leq", longint'(leq), 0);
    chk("reset_zero", longint'(zero), 0);
    chk("reset_busy", longint'(busy), 0);
    rst = 1'b0;
    @(negedge clk);

    // Latency of a lone request on lane 0.
    lane_a[0] = 144;
    lane_b[0] = 24;
    drive_lanes();
    exp_q.push_back(make_exp(0));
    req = 4'b0001;
    @(posedge clk); @(negedge clk);
    chk("lat_grant", longint'(grant), 1);
    chk("lat_busy", longint'(busy), 1);
    chk("lat_no_done_yet", longint'(done), 0);
    req = '0;
    @(posedge clk); @(negedge clk);
    chk("lat_done_grant_held", longint'(grant), 1);
    @(posedge clk); @(negedge clk);
    chk("lat_grant_cleared", longint'(grant), 0);
    chk("lat_done_cleared", longint'(done), 0);
    chk("lat_busy_low", longint'(busy), 0);
    model_rr = 1;

    // Directed operand patterns and boundaries.
    single(2, 49, 229);
    single(2, 191, 192);
    single(1, 163, 163);
    single(1, 247, 247);
    single(0, 0, 0);
    single(3, 255, 255);
    single(3, 0, 255);
    single(2, 255, 0);
    single(0, 1, 0);

    // Contention: all held through five grants, then lane 0 dropped.
    for (int i = 0; i < N; i++) begin
      lane_a[i] = 10 * i + 3;
      lane_b[i] = 20 + i;
    end
    run_batch(4'b1111, 5, 1'b0);
    run_batch(4'b1110, 0, 1'b0);

    // Operands changed after grant must not affect the result.
    lane_a[0] = 144;
    lane_b[0] = 24;
    run_batch(4'b0001, 0, 1'b1);

    // Abort in COMPARE: leave leq/zero set beforehand so the clear is visible.
    single(1, 7, 7);
    lane_a[2] = 10;
    lane_b[2] = 200;
    drive_lanes();
    req = 4'b0100;
    @(posedge clk); @(negedge clk);
    chk("abort_grant", longint'(grant), 4);
    rst = 1'b1;
    @(posedge clk); @(negedge clk);
    chk("abort_grant_clr", longint'(grant), 0);
    chk("abort_done_clr", longint'(done), 0);
    chk("abort_leq_clr", longint'(leq), 0);
    chk("abort_zero_clr", longint'(zero), 0);
    chk("abort_busy_clr", longint'(busy), 0);
`ifdef CMP_ARBITER_COUNT_EN
    chk("abort_count_clr", longint'(cmp_count), 0);
`endif
    rst       = 1'b0;
    req       = '0;
    model_rr  = 0;
    exp_count = 0;
    @(negedge clk);
    lane_a[0] = 50;  lane_b[0] = 60;
    lane_a[3] = 60;  lane_b[3] = 50;
    run_batch(4'b1001, 0, 1'b0);

    // Randomized batches.
    for (int t = 0; t < 60; t++) begin
      logic [N-1:0] mask;
      int holds;
      int mode;
      mask = N'($urandom_range(1, (1 << N) - 1));
      for (int i = 0; i < N; i++) begin
        lane_a[i] = $urandom_range(0, 255);
        mode = $urandom_range(0, 3);
        if (mode == 0) lane_b[i] = lane_a[i];
        else if (mode == 1) lane_b[i] = (lane_a[i] + 1) % 256;
        else lane_b[i] = $urandom_range(0, 255);
      end
      holds = ($urandom_range(0, 7) == 0) ? $urandom_range(2, 6) : 0;
      run_batch(mask, holds, (holds == 0) ? 1'($urandom_range(0, 1)) : 1'b0);
    end

    repeat (4) @(negedge clk);
    chk("scoreboard_empty", exp_q.size(), 0);
`ifdef CMP_ARBITER_COUNT_EN
    chk("cmp_count", longint'(cmp_count), exp_count);
`endif
    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

endmodule

// File: doc/cmp_arbiter.md
Name: cmp_arbiter

Overview:
- Shares one 8-bit magnitude comparator (leq/zero outputs) between N_REQ requesters.
- Arbitration is round-robin.
- Each requester raises req with its operand pair. The arbiter grants one requester, latches its operands, runs a single compare, and returns leq/zero with a one-cycle done pulse to that requester.
- Sits between the datapath clients and the shared comparator core.

Parameters:
- N_REQ, 4, number of requesters; legal range 1..8.
- DATA_W, 8, operand width; the comparator is fixed at 8, so only 8 is supported.

Ports:
- clk  input  1  rising-edge clock
- rst  input  1  synchronous, active-high reset
- req  input  N_REQ  per-requester compare request; level, held until done
- a_flat  input  N_REQ*8  operand A; lane i is bits [8i+7:8i]
- b_flat  input  N_REQ*8  operand B; same lane packing
- grant  output  N_REQ  one-hot; high while that requester owns the comparator
- done  output  N_REQ  one-hot, one-cycle pulse; result valid for that requester
- leq  output  1  registered result: unsigned A <= B
- zero  output  1  registered result: A == B
- busy  output  1  high in any state other than IDLE

Behaviour:
- Reset, synchronous, active-high: state=IDLE, grant=0, done=0, leq=0, zero=0, busy=0, rr_ptr=0 (requester 0 has top priority).
- FSM states: IDLE, COMPARE, RESP.
- IDLE:
  - If req != 0, select the first asserted req at or after rr_ptr (wrapping modulo N_REQ).
  - Latch lane g into op_a and op_b; set grant[g]=1, busy=1; go to COMPARE.
  - Otherwise stay in IDLE.
- COMPARE:
  - Core evaluates op_a + ~op_b + 1 (cin=1); cout=1 iff op_a >= op_b.
  - Register zero = (op_a == op_b) and leq = ~cout | zero.
  - Set done[g]=1; go to RESP.
- RESP:
  - done=0, grant=0, rr_ptr = (g+1) mod N_REQ; go to IDLE.
  - busy drops on the following edge.
- Latency: req sampled at edge T → grant visible after T+1 → done, leq, zero visible after T+2. Throughput is one compare per 3 cycles.
- leq/zero hold their value until the next done; they are only meaningful when done is high.
- Operands are latched at grant; changes to a_flat/b_flat after grant are ignored.
- If req drops while granted, the compare still completes and done still pulses.
- A requester that keeps req high through RESP is re-arbitrated. Because rr_ptr has advanced, other pending requesters win first.
- Simultaneous requests are served strictly in round-robin order; no requester waits more than N_REQ-1 grants.
- rst asserted mid-operation aborts immediately: no done pulse, all outputs return to reset values.
- N_REQ=1 is degenerate but legal: rr_ptr is always 0.

Optional Feature:
- Macro: CMP_ARBITER_COUNT_EN.
- Defined:
  - Adds output cmp_count, 16 bits: number of completed compares (done pulses).
  - Increments in COMPARE; saturates at 16'hFFFF; cleared by rst; not incremented by aborted operations.
- Undefined: the port and counter are absent; behaviour is otherwise identical.

Decomposition:
- Package cmp_arbiter_pkg holds:
  - CMP_W = 8
  - state encodings: IDLE=2'd0, COMPARE=2'd1, RESP=2'd2
  - COUNT_W = 16
- One sub-module, cmp_core: purely combinational 8-bit compare.
  - Inputs: a, b, cin. Outputs: leq, zero.
  - Uses the add-with-complement form above.
  - Instantiated once, driven by op_a/op_b with cin tied to 1.

Test Plan:
- Single request: req=4'b0001, lane0 A=144, B=24 → grant=0001 one cycle later; done=0001 two cycles after req sampled; leq=0, zero=0; busy falls 3 cycles after the request.
- Less-than: lane2 A=49, B=229 → done=0100, leq=1, zero=0. Repeat with A=191, B=192 → leq=1, zero=0.
- Equal: lane1 A=B=163, then A=B=247 → leq=1, zero=1 on each done=0010.
- Contention:
  - All four req held high from reset → grant order 0,1,2,3,0, each 3 cycles apart.
  - Then drop req0 → next order 1,2,3.
- Operand stability and reset:
  - Change lane0 A from 144 to 12 the cycle after grant → result still leq=0 (144 vs 24).
  - Assert rst in the COMPARE cycle → no done pulse, all outputs 0, next grant goes to requester 0.
- CMP_ARBITER_COUNT_EN defined:
  - 5 completed compares → cmp_count=5; an aborted op leaves it at 5; rst clears it to 0.
  - Force the counter to 16'hFFFE and run 3 compares → count sticks at 16'hFFFF.
